// File: rtl/rgb_fade_pwm.sv
// rgb_fade_pwm: three-channel 8-bit PWM LED driver with linear duty fading.
// Each channel ramps one duty step per RAMP_DIV cycles toward
// (colour bit ? sampled level : 0). The duty in use is latched once per PWM
// period, so the on-width never changes inside a period.
module rgb_fade_pwm #(
   parameter int unsigned RAMP_DIV   = 1024,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [2:0] i_colour,
   input  logic [7:0] i_level,
   output logic       o_ledr,
   output logic       o_ledg,
   output logic       o_ledb,
   output logic       o_settled
);

   localparam logic [15:0] DIV_LAST = 16'(RAMP_DIV - 1);

   // Channel index follows i_colour: 2 = red, 1 = green, 0 = blue.
   logic [7:0]      pwm_cnt_q, pwm_cnt_d;
   logic [15:0]     div_cnt_q, div_cnt_d;
   logic [7:0]      level_q, level_d;
   logic [2:0][7:0] duty_q, duty_d;
   logic [2:0][7:0] duty_act_q, duty_act_d;
   logic [2:0][7:0] target;
   logic [2:0]      led_q, led_d;
   logic            settled_q, settled_d;
   logic            tick;
   logic            wrap;

   assign tick = (div_cnt_q == DIV_LAST);
   assign wrap = (pwm_cnt_q == 8'hFF);

   // Per-channel target: sampled brightness when requested on, else dark.
   always_comb begin
      target = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         target[i] = i_colour[i] ? level_q : 8'd0;
      end
   end

   // Next-state: counters, level sample, unit-step ramp, period latch, compare.
   always_comb begin
      pwm_cnt_d  = pwm_cnt_q + 8'd1;
      div_cnt_d  = tick ? 16'd0 : div_cnt_q + 16'd1;
      level_d    = wrap ? i_level : level_q;
      duty_d     = duty_q;
      duty_act_d = wrap ? duty_q : duty_act_q;
      led_d      = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         if (tick) begin
            if (duty_q[i] < target[i]) begin
               duty_d[i] = duty_q[i] + 8'd1;
            end else if (duty_q[i] > target[i]) begin
               duty_d[i] = duty_q[i] - 8'd1;
            end
         end
         led_d[i] = (pwm_cnt_q < duty_act_q[i]);
      end
      settled_d = (duty_q == target);
   end

   // State register; reset leaves LEDs dark and the ramp reported as settled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pwm_cnt_q  <= '0;
         div_cnt_q  <= '0;
         level_q    <= '0;
         duty_q     <= '0;
         duty_act_q <= '0;
         led_q      <= '0;
         settled_q  <= 1'b1;
      end else begin
         pwm_cnt_q  <= pwm_cnt_d;
         div_cnt_q  <= div_cnt_d;
         level_q    <= level_d;
         duty_q     <= duty_d;
         duty_act_q <= duty_act_d;
         led_q      <= led_d;
         settled_q  <= settled_d;
      end
   end

   assign o_ledr    = led_q[2] ^ ACTIVE_LOW;
   assign o_ledg    = led_q[1] ^ ACTIVE_LOW;
   assign o_ledb    = led_q[0] ^ ACTIVE_LOW;
   assign o_settled = settled_q;

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Directed bench for rgb_fade_pwm with RAMP_DIV = 4. Expected values are
// hand-derived from a cycle count kept by the bench (cyc = rising edges since
// reset release); outputs are sampled on the falling edge.
module tb_rgb_fade_pwm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] colour = 3'b100;
   logic [7:0] level = 8'd8;
   logic       ledr, ledg, ledb, settled;
   logic       nledr, nledg, nledb, nsettled;
   int         cyc = 0;
   int         tests = 0;
   int         failed = 0;
   int         nr, ng, nb;

   rgb_fade_pwm #(.RAMP_DIV(4), .ACTIVE_LOW(1'b0)) dut (
      .i_clk(clk), .i_rst(rst), .i_colour(colour), .i_level(level),
      .o_ledr(ledr), .o_ledg(ledg), .o_ledb(ledb), .o_settled(settled)
   );

   rgb_fade_pwm #(.RAMP_DIV(4), .ACTIVE_LOW(1'b1)) dut_n (
      .i_clk(clk), .i_rst(rst), .i_colour(colour), .i_level(level),
      .o_ledr(nledr), .o_ledg(nledg), .o_ledb(nledb), .o_settled(nsettled)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc = 0;
      else     cyc = cyc + 1;
   end

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic goto(input int n);
      int guard = 0;
      while (cyc < n && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != n) begin
         failed++;
         $error("FAIL goto: at cyc %0d wanted %0d", cyc, n);
      end
   endtask

   // On-cycle counts over 256 consecutive samples starting at cycle 'start';
   // optionally changes i_level right after sampling cycle 'chg_cyc'.
   task automatic count_period(input int start, input int chg_cyc, input logic [7:0] chg_lvl,
                               output int r, output int g, output int b);
      r = 0; g = 0; b = 0;
      for (int i = 0; i < 256; i++) begin
         goto(start + i);
         r += int'(ledr);
         g += int'(ledg);
         b += int'(ledb);
         if (cyc == chg_cyc) level = chg_lvl;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      // Reset values, both polarities.
      check("rst_ledr", ledr, 0);
      check("rst_ledg", ledg, 0);
      check("rst_ledb", ledb, 0);
      check("rst_settled", settled, 1);
      check("rst_nledr", nledr, 1);
      check("rst_nledg", nledg, 1);
      check("rst_nledb", nledb, 1);
      check("rst_nsettled", nsettled, 1);
      rst = 1'b0;

      // Basic ramp: level sampled at 256, red ramps 0->8 by cycle 288.
      goto(256); check("ramp_settled_pre", settled, 1);
      goto(257); check("ramp_settled_fall", settled, 0);
      goto(288); check("ramp_settled_288", settled, 0);
      goto(289); check("ramp_settled_rise", settled, 1);
      goto(512); check("ramp_ledr_prev_period", ledr, 0);
      goto(513); check("ramp_ledr_first_on", ledr, 1);
      check("ramp_nledr_first_on", nledr, 0);
      goto(520); check("ramp_ledr_last_on", ledr, 1);
      goto(521); check("ramp_ledr_first_off", ledr, 0);
      count_period(769, -1, 8'd0, nr, ng, nb);
      check("ramp_on_r", nr, 8);
      check("ramp_on_g", ng, 0);
      check("ramp_on_b", nb, 0);

      // Reversal: green up 0..5, then drop it; 5 ticks down, settled at 1065.
      goto(1024); colour = 3'b110;
      goto(1025); check("rev_settled_fall", settled, 0);
      goto(1044); colour = 3'b100;
      goto(1064); check("rev_settled_1064", settled, 0);
      goto(1065); check("rev_settled_rise", settled, 1);

      // Full-scale: level 255 sampled at 1280, red 8->255 done at 2268.
      level = 8'd255;
      goto(1281); check("full_settled_fall", settled, 0);
      goto(2268); check("full_settled_2268", settled, 0);
      goto(2269); check("full_settled_rise", settled, 1);
      count_period(2305, -1, 8'd0, nr, ng, nb);
      check("full_on_r255", nr, 255);
      check("full_off_slot", ledr, 0);
      goto(2561); check("full_next_on", ledr, 1);

      // Level 255->1 at pwm_cnt 100: current period keeps 255.
      count_period(2561, 2660, 8'd1, nr, ng, nb);
      check("glitch_keep_255", nr, 255);
      goto(2817); check("glitch_settled_fall", settled, 0);
      // Tick coincides with wrap: pre-tick duties 192 then 128 are latched.
      count_period(3073, -1, 8'd0, nr, ng, nb);
      check("sim_on_192", nr, 192);
      count_period(3329, -1, 8'd0, nr, ng, nb);
      check("sim_on_128", nr, 128);

      // Asynchronous reset between edges while red is on.
      goto(3585);
      check("arst_pre_ledr", ledr, 1);
      check("arst_pre_nledr", nledr, 0);
      check("arst_pre_settled", settled, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_ledr", ledr, 0);
      check("arst_nledr", nledr, 1);
      check("arst_settled", settled, 1);
      @(negedge clk);
      rst = 1'b0;

      // Restart from duty 0 with level 1; then swap red for blue.
      goto(10);  check("re_ledr", ledr, 0);
      goto(256); check("re_settled_pre", settled, 1);
      goto(257); check("re_settled_fall", settled, 0);
      goto(260); check("re_settled_260", settled, 0);
      goto(261); check("re_settled_rise", settled, 1);
      colour = 3'b001;
      goto(262); check("blue_settled_fall", settled, 0);
      goto(265); check("blue_settled_rise", settled, 1);
      count_period(513, -1, 8'd0, nr, ng, nb);
      check("blue_on_r", nr, 0);
      check("blue_on_g", ng, 0);
      check("blue_on_b", nb, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
